// File: rtl/dma_copy_master.sv
// dma_copy_master: single-channel memory-to-memory copy engine.
// Moves cfg_len elements as read-then-write pairs on the dmem port.
module dma_copy_master #(
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [31:0]     cfg_src,
  input  logic [31:0]     cfg_dst,
  input  logic [LENW-1:0] cfg_len,
  input  logic [1:0]      cfg_size,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [LENW-1:0] remaining,
  output logic [31:0]     dmem_addr,
  output logic [1:0]      dmem_size,
  output logic            dmem_read_en,
  output logic            dmem_write_en,
  output logic [31:0]     dmem_write_data,
  input  logic [31:0]     dmem_read_data,
  input  logic            dmem_ready,
  input  logic            fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RDW, S_WR, S_WRW, S_DONE
  } state_t;

  state_t      state;
  logic [31:0] src;
  logic [31:0] dst;
  logic [31:0] step;
  logic [31:0] rd_mask;
  logic        cfg_bad;
  logic        rd_acc;
  logic        wr_acc;

  assign rd_acc = dmem_read_en & dmem_ready;
  assign wr_acc = dmem_write_en & dmem_ready;
  assign step   = 32'd1 << dmem_size;

  always_comb begin
    cfg_bad = 1'b0;
    unique case (cfg_size)
      2'b00:   cfg_bad = 1'b0;
      2'b01:   cfg_bad = cfg_src[0] | cfg_dst[0];
      2'b10:   cfg_bad = (|cfg_src[1:0]) | (|cfg_dst[1:0]);
      default: cfg_bad = 1'b1;
    endcase
  end

  // keep sub-word data right-justified with clean upper bits
  always_comb begin
    rd_mask = 32'hFFFF_FFFF;
    unique case (dmem_size)
      2'b00:   rd_mask = 32'h0000_00FF;
      2'b01:   rd_mask = 32'h0000_FFFF;
      default: rd_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      remaining       <= '0;
      dmem_addr       <= '0;
      dmem_size       <= '0;
      dmem_read_en    <= 1'b0;
      dmem_write_en   <= 1'b0;
      dmem_write_data <= '0;
      src             <= '0;
      dst             <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              err       <= 1'b0;
              src       <= cfg_src;
              dst       <= cfg_dst;
              remaining <= cfg_len;
              dmem_size <= cfg_size;
              if (cfg_len == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state        <= S_RD;
                busy         <= 1'b1;
                dmem_read_en <= 1'b1;
                dmem_addr    <= cfg_src;
              end
            end
          end
        end
        S_RD: begin
          if (abort) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            dmem_read_en <= 1'b0;
          end else if (rd_acc) begin
            state        <= S_RDW;
            dmem_read_en <= 1'b0;
          end
        end
        S_RDW: begin
          dmem_write_data <= dmem_read_data & rd_mask;
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (fault) begin
            err   <= 1'b1;
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state         <= S_WR;
            dmem_write_en <= 1'b1;
            dmem_addr     <= dst;
          end
        end
        S_WR: begin
          // a write accepted alongside abort still advances
          if (wr_acc) begin
            src       <= src + step;
            dst       <= dst + step;
            remaining <= remaining - LENW'(1);
          end
          if (abort) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            dmem_write_en <= 1'b0;
          end else if (wr_acc) begin
            state         <= S_WRW;
            dmem_write_en <= 1'b0;
          end
        end
        S_WRW: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (fault) begin
            err   <= 1'b1;
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (remaining == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state        <= S_RD;
            dmem_read_en <= 1'b1;
            dmem_addr    <= src;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_master.sv
// tb_dma_copy_master: directed copies against a byte memory model,
// bus transactions checked by a scoreboard monitor.
module tb_dma_copy_master;

  localparam int LENW = 16;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [31:0]     cfg_src = '0;
  logic [31:0]     cfg_dst = '0;
  logic [LENW-1:0] cfg_len = '0;
  logic [1:0]      cfg_size = '0;
  logic            busy, done, err;
  logic [LENW-1:0] remaining;
  logic [31:0]     dmem_addr;
  logic [1:0]      dmem_size;
  logic            dmem_read_en, dmem_write_en;
  logic [31:0]     dmem_write_data;
  logic [31:0]     dmem_read_data = '0;
  logic            dmem_ready = 1'b1;
  logic            fault = 1'b0;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;
  int   fault_on_write = -1;
  int   rd_stall = 0;
  int   wr_stall = 0;
  bit   fault_pend = 1'b0;
  bit   prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [1:0]  prev_en = '0;
  txn_t exp_q[$];
  txn_t mt;
  logic [7:0] mem [0:1023];

  dma_copy_master #(.LENW(LENW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst),
    .cfg_len(cfg_len), .cfg_size(cfg_size),
    .busy(busy), .done(done), .err(err), .remaining(remaining),
    .dmem_addr(dmem_addr), .dmem_size(dmem_size),
    .dmem_read_en(dmem_read_en), .dmem_write_en(dmem_write_en),
    .dmem_write_data(dmem_write_data),
    .dmem_read_data(dmem_read_data),
    .dmem_ready(dmem_ready), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a,
                                         input logic [1:0] sz);
    int i = int'(a[9:0]);
    case (sz)
      2'b00:   return {24'd0, mem[i]};
      2'b01:   return {16'd0, mem[i+1], mem[i]};
      default: return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endcase
  endfunction

  // ready for the coming edge is chosen just after each edge
  always @(posedge clk) begin
    #1;
    if (dmem_read_en && rd_stall > 0) begin
      dmem_ready = 1'b0;
      rd_stall--;
    end else if (dmem_write_en && wr_stall > 0) begin
      dmem_ready = 1'b0;
      wr_stall--;
    end else begin
      dmem_ready = 1'b1;
    end
  end

  // memory model: data/fault presented for the cycle after acceptance
  always @(negedge clk) begin
    int n;
    int a;
    fault = fault_pend;
    fault_pend = 1'b0;
    if (dmem_read_en && dmem_ready)
      dmem_read_data = rd_mem(dmem_addr, dmem_size);
    if (dmem_write_en && dmem_ready) begin
      n = (dmem_size == 2'b00) ? 1 : (dmem_size == 2'b01) ? 2 : 4;
      a = int'(dmem_addr[9:0]);
      for (int k = 0; k < n; k++)
        mem[a+k] = dmem_write_data[8*k +: 8];
      if (wr_cnt == fault_on_write) fault_pend = 1'b1;
      wr_cnt++;
    end
  end

  // monitor: pops expected bus transactions on acceptance
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dmem_read_en || dmem_write_en) begin
      chk("rd_wr_exclusive", {31'd0, dmem_read_en & dmem_write_en}, 32'd0);
      if (!dmem_ready) begin
        if (prev_stall) begin
          chk("stall_addr", dmem_addr, prev_addr);
          chk("stall_en", {30'd0, dmem_read_en, dmem_write_en},
              {30'd0, prev_en});
        end
        prev_stall = 1'b1;
        prev_addr = dmem_addr;
        prev_en = {dmem_read_en, dmem_write_en};
      end else begin
        prev_stall = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_access: addr %h wr %0d, none expected",
                   dmem_addr, dmem_write_en);
        end else begin
          mt = exp_q.pop_front();
          chk("txn_kind", {31'd0, dmem_write_en}, {31'd0, mt.wr});
          chk("txn_addr", dmem_addr, mt.addr);
          if (mt.wr) chk("txn_wdata", dmem_write_data, mt.data);
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_exp(input logic [31:0] s, input logic [31:0] d,
                          input int n, input logic [1:0] sz);
    logic [31:0] st;
    st = 32'd1 << sz;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{wr: 1'b0, addr: s + i * st, data: 32'd0});
      exp_q.push_back('{wr: 1'b1, addr: d + i * st,
                        data: rd_mem(s + i * st, sz)});
    end
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d,
                             input int n, input logic [1:0] sz);
    cfg_src = s;
    cfg_dst = d;
    cfg_len = LENW'(n);
    cfg_size = sz;
    wr_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_copy(input string nm, input logic [31:0] s,
                          input logic [31:0] d, input int n,
                          input logic [1:0] sz, input int exp_cyc);
    int cyc;
    int d0;
    push_exp(s, d, n, sz);
    d0 = done_cnt;
    pulse_start(s, d, n, sz);
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_cycles"}, cyc, exp_cyc);
    chk({nm, "_err"}, {31'd0, err}, 32'd0);
    chk({nm, "_remaining"}, 32'(remaining), 32'd0);
    chk({nm, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({nm, "_done_pulses"}, done_cnt - d0, 32'd1);
    chk({nm, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int d0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_en", {30'd0, dmem_read_en, dmem_write_en}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_size_wdata", {30'd0, dmem_size} | dmem_write_data, 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_copy("word4", 32'h100, 32'h200, 4, 2'b10, 17);
    run_copy("byte3", 32'h101, 32'h303, 3, 2'b00, 13);
    run_copy("half2", 32'h122, 32'h3A6, 2, 2'b01, 9);
    run_copy("len0", 32'h100, 32'h200, 0, 2'b10, 1);

    pulse_start(32'h101, 32'h200, 2, 2'b01);
    chk("illegal_half_err", {31'd0, err}, 32'd1);
    chk("illegal_half_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    pulse_start(32'h100, 32'h200, 2, 2'b11);
    chk("illegal_size_err", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk);
    chk("illegal_size_busy", {31'd0, busy}, 32'd0);
    run_copy("after_illegal", 32'h180, 32'h2C0, 1, 2'b10, 5);

    rd_stall = 3;
    wr_stall = 3;
    run_copy("stall", 32'h140, 32'h280, 2, 2'b10, 15);

    push_exp(32'h1A0, 32'h2E0, 2, 2'b10);
    fault_on_write = 1;
    d0 = done_cnt;
    pulse_start(32'h1A0, 32'h2E0, 5, 2'b10);
    cyc = 1;
    while (busy && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("fault_cycles", cyc, 32'd9);
    chk("fault_err", {31'd0, err}, 32'd1);
    chk("fault_remaining", 32'(remaining), 32'd3);
    repeat (4) @(negedge clk);
    chk("fault_no_done", done_cnt - d0, 32'd0);
    fault_on_write = -1;

    exp_q.push_back('{wr: 1'b0, addr: 32'h100, data: 32'd0});
    d0 = done_cnt;
    pulse_start(32'h100, 32'h320, 2, 2'b10);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_en", {30'd0, dmem_read_en, dmem_write_en}, 32'd0);
    chk("abort_err_cleared_by_start", {31'd0, err}, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 32'd0);

    exp_q.push_back('{wr: 1'b0, addr: 32'h110, data: 32'd0});
    exp_q.push_back('{wr: 1'b1, addr: 32'h340,
                      data: rd_mem(32'h110, 2'b10)});
    pulse_start(32'h110, 32'h340, 2, 2'b10);
    repeat (2) @(negedge clk);
    chk("pre_rst_in_wr", {31'd0, dmem_write_en}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("midrst_en", {30'd0, dmem_read_en, dmem_write_en}, 32'd0);
    chk("midrst_addr", dmem_addr, 32'd0);
    chk("midrst_wdata", dmem_write_data, 32'd0);
    chk("midrst_size_rem", {14'd0, dmem_size, remaining}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
